lcd_reader: RTL and testbench

//  Read-side engine for the HD44780-compatible character LCD in 8-bit mode (RW=1 cycles).

---
 rtl/lcd_pkg.sv | 46 ++++
 rtl/lcd_phase_timer.sv | 38 +++
 rtl/lcd_reader.sv | 177 +++++++++++++++++
 tb/tb_lcd_reader.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared definitions for the HD44780 character-LCD engines (reader
// and writer). Holds the request op encodings, the common HD44780 command
// bytes, the default bus timing at 50 MHz, the reader state encoding and a
// small helper used to size phase counters.
package lcd_pkg;

    // Request op encodings. Op 3 is reserved and is handled as a status read.
    localparam logic [1:0] LCD_OP_STATUS    = 2'd0;
    localparam logic [1:0] LCD_OP_DATA      = 2'd1;
    localparam logic [1:0] LCD_OP_WAIT_IDLE = 2'd2;

    // HD44780 command bytes used by the write sequencer.
    localparam logic [7:0] LCD_CMD_FUNC_SET = 8'h38;  // 8-bit, 2 lines, 5x8 font
    localparam logic [7:0] LCD_CMD_DISP_ON  = 8'h0C;  // display on, cursor off
    localparam logic [7:0] LCD_CMD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME     = 8'h02;

    // Default bus timing in 50 MHz clocks.
    localparam int LCD_SETUP_CYC   = 3;     // tAS
    localparam int LCD_EN_HIGH_CYC = 25;    // PW_EH >= 450 ns
    localparam int LCD_SAMPLE_CYC  = 21;    // tDDR: EN-high clock that captures the bus
    localparam int LCD_HOLD_CYC    = 2;     // tAH
    localparam int LCD_GAP_CYC     = 25;    // pads the cycle out to tcycE >= 1000 ns
    localparam int LCD_POLL_MAX    = 2500;  // status reads before WAIT_IDLE gives up

    // Reader FSM states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_EN_HI = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4,
        ST_RESP  = 3'd5
    } lcd_rd_state_t;

    // Largest of four phase lengths; sizes the shared phase counter.
    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// lcd_phase_timer: load-and-count-down timer shared by the LCD engines.
// A load of N makes the timer run for exactly N clocks; done is high during
// the last of those clocks, so a caller that reloads on done gets back-to-back
// phases of exact length.
// Ports:
//   clk       system clock
//   rst       asynchronous reset, active-low
//   load      load load_val this clock (takes priority over counting)
//   load_val  phase length in clocks (>= 1)
//   count     clocks remaining in the phase, including the current one
//   done      high on the final clock of the phase
module lcd_phase_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         done
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign count = cnt_q;
    assign done  = (cnt_q == W'(1));

endmodule

// File: rtl/lcd_reader.sv
// lcd_reader: read-side engine for an HD44780 LCD in 8-bit mode. Each
// accepted request runs one RW=1 bus cycle (SETUP, EN_HI, HOLD, GAP) and
// returns the captured byte; WAIT_IDLE repeats status reads until the busy
// flag clears or POLL_MAX reads have been made.
// Handshakes: a transfer happens on a clock edge where valid and ready are
// both high. req_ready is high only in IDLE; req_valid at any other time is
// ignored and not queued. rsp_valid and all rsp_* hold steady until
// rsp_ready is seen; a new request cannot be accepted on that same edge.
// Ports:
//   clk, rst           clock; asynchronous active-low reset
//   req_valid/ready/op request handshake and op (see lcd_pkg)
//   rsp_valid/ready    response handshake
//   rsp_data           raw captured byte
//   rsp_busy/rsp_addr  busy flag / address counter for status ops, else 0
//   rsp_timeout        WAIT_IDLE ended with BF still set
//   active             bus cycle in progress; top mux must tri-state data
//   lcd_en/rw/rs       LCD control pins (registered)
//   lcd_data_i         LCD data bus input
//   dbg_state          current FSM state
module lcd_reader
    import lcd_pkg::*;
#(
    parameter int SETUP_CYC   = LCD_SETUP_CYC,
    parameter int EN_HIGH_CYC = LCD_EN_HIGH_CYC,
    parameter int SAMPLE_CYC  = LCD_SAMPLE_CYC,
    parameter int HOLD_CYC    = LCD_HOLD_CYC,
    parameter int GAP_CYC     = LCD_GAP_CYC,
    parameter int POLL_MAX    = LCD_POLL_MAX
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_op,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_busy,
    output logic [6:0] rsp_addr,
    output logic       rsp_timeout,
    output logic       active,
    output logic       lcd_en,
    output logic       lcd_rw,
    output logic       lcd_rs,
    input  logic [7:0] lcd_data_i,
    output logic [2:0] dbg_state
);

    localparam int MAX_CYC = max4(SETUP_CYC, EN_HIGH_CYC, HOLD_CYC, GAP_CYC);
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam int PW      = $clog2(POLL_MAX) + 1;

    // The timer counts down from EN_HIGH_CYC, so the k-th EN_HI clock sees
    // count = EN_HIGH_CYC - k + 1.
    localparam logic [CW-1:0] SAMPLE_AT = CW'(EN_HIGH_CYC - SAMPLE_CYC + 1);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX - 1);

    lcd_rd_state_t state_q, state_d;
    logic [1:0]    op_q, op_d;
    logic [PW-1:0] poll_q, poll_d;
    logic [7:0]    sample_q;
    logic          en_q, rw_q, rs_q;
    logic          bus_phase_d;

    logic          tmr_load;
    logic [CW-1:0] tmr_val;
    logic [CW-1:0] tmr_cnt;
    logic          tmr_done;

    lcd_phase_timer #(.W(CW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .count    (tmr_cnt),
        .done     (tmr_done)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        poll_d   = poll_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d     = req_op;
                    poll_d   = '0;
                    tmr_load = 1'b1;
                    tmr_val  = CW'(SETUP_CYC);
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    tmr_val  = CW'(EN_HIGH_CYC);
                    state_d  = ST_EN_HI;
                end
            end
            ST_EN_HI: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    tmr_val  = CW'(HOLD_CYC);
                    state_d  = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    tmr_val  = CW'(GAP_CYC);
                    state_d  = ST_GAP;
                end
            end
            ST_GAP: begin
                if (tmr_done) begin
                    // sample_q already holds this cycle's byte (captured in EN_HI).
                    if (op_q == LCD_OP_WAIT_IDLE && sample_q[7] && poll_q < POLL_LAST) begin
                        poll_d   = poll_q + 1'b1;
                        tmr_load = 1'b1;
                        tmr_val  = CW'(SETUP_CYC);
                        state_d  = ST_SETUP;
                    end else begin
                        state_d  = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // RS/RW are driven from SETUP through HOLD and released in GAP.
    assign bus_phase_d = (state_d == ST_SETUP) || (state_d == ST_EN_HI) || (state_d == ST_HOLD);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            op_q     <= LCD_OP_STATUS;
            poll_q   <= '0;
            sample_q <= '0;
            en_q     <= 1'b0;
            rw_q     <= 1'b0;
            rs_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            poll_q  <= poll_d;
            en_q    <= (state_d == ST_EN_HI);
            rw_q    <= bus_phase_d;
            rs_q    <= bus_phase_d && (op_d == LCD_OP_DATA);
            if (state_q == ST_EN_HI && tmr_cnt == SAMPLE_AT) begin
                sample_q <= lcd_data_i;
            end
        end
    end

    logic is_status;
    assign is_status = (op_q != LCD_OP_DATA);

    assign req_ready   = (state_q == ST_IDLE);
    assign rsp_valid   = (state_q == ST_RESP);
    assign rsp_data    = rsp_valid ? sample_q : 8'd0;
    assign rsp_busy    = rsp_valid && is_status && sample_q[7];
    assign rsp_addr    = (rsp_valid && is_status) ? sample_q[6:0] : 7'd0;
    assign rsp_timeout = rsp_valid && (op_q == LCD_OP_WAIT_IDLE) && sample_q[7];
    assign active      = (state_q == ST_SETUP) || (state_q == ST_EN_HI) ||
                         (state_q == ST_HOLD)  || (state_q == ST_GAP);
    assign lcd_en      = en_q;
    assign lcd_rw      = rw_q;
    assign lcd_rs      = rs_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_lcd_reader.sv
// tb_lcd_reader: randomized and directed stimulus for lcd_reader with a
// queue-based scoreboard. Expected responses come from a behavioural model
// of the LCD read rules; a monitor process compares on each response.
module tb_lcd_reader;
    import lcd_pkg::*;

    localparam int SETUP    = 2;
    localparam int EN_HIGH  = 5;
    localparam int SAMPLE   = 4;
    localparam int HOLD     = 1;
    localparam int GAP      = 3;
    localparam int POLL_MAX = 4;
    localparam int READ_LEN = SETUP + EN_HIGH + HOLD + GAP;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_valid = 1'b0;
    logic [1:0] req_op = 2'd0;
    logic       rsp_ready = 1'b0;
    logic [7:0] lcd_data_i = 8'd0;
    logic       req_ready, rsp_valid, rsp_busy, rsp_timeout, active;
    logic       lcd_en, lcd_rw, lcd_rs;
    logic [7:0] rsp_data;
    logic [6:0] rsp_addr;
    logic [2:0] dbg_state;

    always #5 clk = ~clk;

    lcd_reader #(
        .SETUP_CYC   (SETUP),
        .EN_HIGH_CYC (EN_HIGH),
        .SAMPLE_CYC  (SAMPLE),
        .HOLD_CYC    (HOLD),
        .GAP_CYC     (GAP),
        .POLL_MAX    (POLL_MAX)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_busy    (rsp_busy),
        .rsp_addr    (rsp_addr),
        .rsp_timeout (rsp_timeout),
        .active      (active),
        .lcd_en      (lcd_en),
        .lcd_rw      (lcd_rw),
        .lcd_rs      (lcd_rs),
        .lcd_data_i  (lcd_data_i),
        .dbg_state   (dbg_state)
    );

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ---------------- scoreboard state ----------------
    int         checks = 0;
    int         failures = 0;
    logic [16:0] exp_q[$];      // {timeout, busy, addr, data}
    int         exp_pulse_q[$];
    int         exp_lat_q[$];
    int         acc_q[$];
    logic [7:0] bus_q[$];       // byte the LCD presents on each successive read
    logic [7:0] plan[$];        // bus bytes offered for the next request
    logic       exp_rs = 1'b0;
    int         rdy_mode = 2;   // 0 random, 1 held low, 2 held high

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic finish_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    task automatic bound_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
        finish_run();
    endtask

    // ---------------- driver tasks ----------------
    // Reference model: one read for status/data ops; WAIT_IDLE keeps reading
    // while BF is set, up to POLL_MAX reads.
    task automatic start_req(input logic [1:0] op);
        int         reads;
        logic [7:0] b;
        bit         ok;
        reads = 0;
        b = 8'd0;
        if (op == LCD_OP_WAIT_IDLE) begin
            while (reads < POLL_MAX && reads < plan.size()) begin
                b = plan[reads];
                reads++;
                if (!b[7]) break;
            end
        end else begin
            reads = 1;
            b = plan[0];
        end
        for (int i = 0; i < reads; i++) bus_q.push_back(plan[i]);
        if (op == LCD_OP_DATA) exp_q.push_back({1'b0, 1'b0, 7'd0, b});
        else exp_q.push_back({(op == LCD_OP_WAIT_IDLE) && b[7], b[7], b[6:0], b});
        exp_pulse_q.push_back(reads);
        exp_lat_q.push_back(reads * READ_LEN);
        exp_rs = (op == LCD_OP_DATA);
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_op = op;
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (req_ready) ok = 1;
        end
        if (!ok) bound_fail("req_accept");
        acc_q.push_back(cyc + 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        bit ok;
        ok = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) ok = 1;
        end
        if (!ok) bound_fail("rsp_wait");
        @(posedge clk);
    endtask

    // ---------------- response ready driver ----------------
    initial forever begin
        @(posedge clk); #1;
        case (rdy_mode)
            0:       rsp_ready = ($urandom_range(0, 3) != 0);
            1:       rsp_ready = 1'b0;
            default: rsp_ready = 1'b1;
        endcase
    end

    // ---------------- LCD bus model + monitor ----------------
    initial begin
        logic        en_prev, rv_prev;
        int          en_w, pulses;
        logic [16:0] held, got;
        en_prev = 1'b0; rv_prev = 1'b0; en_w = 0; pulses = 0; held = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                en_prev = 1'b0; rv_prev = 1'b0; en_w = 0; pulses = 0;
            end else begin
                if (lcd_en && !en_prev) begin
                    pulses++;
                    en_w = 1;
                    if (bus_q.size() > 0) lcd_data_i = bus_q.pop_front();
                    check("rd_pins", 32'({lcd_rs, lcd_rw, active}), 32'({exp_rs, 1'b1, 1'b1}));
                end else if (lcd_en) begin
                    en_w++;
                end else if (en_prev) begin
                    check("en_width", 32'(en_w), 32'(EN_HIGH));
                end
                en_prev = lcd_en;

                got = {rsp_timeout, rsp_busy, rsp_addr, rsp_data};
                if (rsp_valid) begin
                    if (!rv_prev) begin
                        if (acc_q.size() == 0 || exp_lat_q.size() == 0) begin
                            checks++; failures++;
                            $display("FAIL rsp_unexpected: rsp_valid rose with no request outstanding, data 0x%0h", got);
                        end else begin
                            check("latency", 32'(cyc - acc_q.pop_front()), 32'(exp_lat_q.pop_front()));
                        end
                    end else begin
                        check("rsp_stable", 32'(got), 32'(held));
                    end
                    held = got;
                    if (rsp_ready) begin
                        if (exp_q.size() == 0) begin
                            checks++; failures++;
                            $display("FAIL rsp_extra: handshake with empty queue, got 0x%0h expected none", got);
                        end else begin
                            check("rsp", 32'(got), 32'(exp_q.pop_front()));
                            check("en_pulses", 32'(pulses), 32'(exp_pulse_q.pop_front()));
                            check("pins_idle", 32'({lcd_en, lcd_rw, lcd_rs, active}), 32'(0));
                        end
                        pulses = 0;
                    end
                end
                rv_prev = rsp_valid;
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int         cnt;
        bit         ok;
        logic [1:0] op;
        logic [7:0] b;

        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_req_ready", 32'(req_ready), 32'(1));
        check("reset_pins", 32'({rsp_valid, lcd_en, lcd_rw, lcd_rs, active}), 32'(0));
        check("reset_rsp", 32'({rsp_timeout, rsp_busy, rsp_addr, rsp_data}), 32'(0));
        check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
        @(posedge clk); #2;
        rst = 1'b1;

        // 1: status read
        plan = '{8'hA5};
        start_req(LCD_OP_STATUS); wait_rsp();
        // 2: data read
        plan = '{8'h41};
        start_req(LCD_OP_DATA); wait_rsp();
        // 3: wait-idle clears on third read
        plan = '{8'h80, 8'h80, 8'h07};
        start_req(LCD_OP_WAIT_IDLE); wait_rsp();
        // 4: wait-idle times out
        plan = '{8'h80, 8'h80, 8'h80, 8'h80};
        start_req(LCD_OP_WAIT_IDLE); wait_rsp();

        // 5: response back-pressure, second request ignored
        rdy_mode = 1;
        plan = '{8'h3C};
        start_req(LCD_OP_STATUS);
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (rsp_valid) ok = 1;
        end
        if (!ok) bound_fail("rsp_valid_wait");
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            req_valid = 1'b1;
            req_op = LCD_OP_DATA;
            @(negedge clk);
            if (req_ready) cnt++;
        end
        check("req_ready_in_resp", 32'(cnt), 32'(0));
        @(posedge clk); #1;
        req_valid = 1'b0;
        rdy_mode = 2;
        wait_rsp();
        @(negedge clk);
        check("idle_after_rsp", 32'({req_ready, rsp_valid}), 32'(2'b10));
        cnt = 0;
        repeat (15) begin
            @(negedge clk);
            if (lcd_en || rsp_valid || active) cnt++;
        end
        check("ignored_req", 32'(cnt), 32'(0));

        // 6: reset during EN_HI abandons the cycle
        exp_rs = 1'b0;
        bus_q.push_back(8'h99);
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_op = LCD_OP_STATUS;
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (req_ready) ok = 1;
        end
        if (!ok) bound_fail("abort_accept");
        @(posedge clk); #1;
        req_valid = 1'b0;
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (lcd_en) ok = 1;
        end
        if (!ok) bound_fail("abort_en_wait");
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        check("abort_pins", 32'({lcd_en, lcd_rw, lcd_rs, active, rsp_valid, req_ready}), 32'(6'b000001));
        bus_q.delete();
        repeat (3) @(negedge clk);
        @(posedge clk); #2;
        rst = 1'b1;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid || lcd_en) cnt++;
        end
        check("no_rsp_after_abort", 32'(cnt), 32'(0));
        plan = '{8'h12};
        start_req(LCD_OP_STATUS); wait_rsp();

        // randomized traffic, including reserved op 3
        rdy_mode = 0;
        repeat (40) begin
            op = 2'($urandom_range(0, 3));
            plan.delete();
            for (int i = 0; i < POLL_MAX; i++) begin
                b = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 9) < 6) b[7] = 1'b1;
                plan.push_back(b);
            end
            start_req(op);
            wait_rsp();
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        @(negedge clk);
        check("queues_drained", 32'(exp_q.size() + acc_q.size() + bus_q.size()), 32'(0));
        finish_run();
    end

endmodule
